// File: rtl/periph_bus_pkg.sv
// Shared types and defaults for the peripheral bus controller.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int          TIMEOUT_DEF  = 255;
    localparam logic [31:0] ERR_WORD_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant: on a tie, the requester not served last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Two-master to one-downstream bus controller: arbitrate, issue one command,
// wait for the response (or time out) and return it to the owning master.
module periph_bus_ctrl
    import periph_bus_pkg::*;
#(
    parameter int          TIMEOUT  = TIMEOUT_DEF,
    parameter logic [31:0] ERR_WORD = ERR_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        cmd_valid,
    output logic        cmd_write,
    output logic [3:0]  cmd_addr,
    output logic [31:0] cmd_data,
    input  logic        cmd_busy,
    input  logic        rsp_stb,
    input  logic [31:0] rsp_word
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      state;
    logic [7:0]  timer;
    logic        last;
    logic        owner;
    logic [1:0]  gnt;
    logic [31:0] rsp_sel;
    logic        rsp_is_err;

    rr_arbiter2 u_arb (
        .req  ({m1_req, m0_req}),
        .last (last),
        .gnt  (gnt)
    );

    // A real response always beats a coincident timeout.
    assign rsp_sel    = rsp_stb ? rsp_word : ERR_WORD;
    assign rsp_is_err = !rsp_stb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            timer     <= '0;
            last      <= 1'b1;
            owner     <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            m0_ack    <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_ack    <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|gnt) begin
                        owner     <= gnt[1];
                        cmd_write <= gnt[1] ? m1_we    : m0_we;
                        cmd_addr  <= gnt[1] ? m1_addr  : m0_addr;
                        cmd_data  <= gnt[1] ? m1_wdata : m0_wdata;
                        cmd_valid <= 1'b1;
                        timer     <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (timer != TMO) timer <= timer + 8'd1;
                    if (!cmd_busy) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (timer != TMO) timer <= timer + 8'd1;
                    if (rsp_stb || timer == TMO) begin
                        m0_ack   <= !owner;
                        m1_ack   <= owner;
                        m0_rdata <= owner ? '0 : rsp_sel;
                        m1_rdata <= owner ? rsp_sel : '0;
                        m0_err   <= !owner && rsp_is_err;
                        m1_err   <= owner && rsp_is_err;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    m0_ack   <= 1'b0;
                    m1_ack   <= 1'b0;
                    m0_rdata <= '0;
                    m1_rdata <= '0;
                    m0_err   <= 1'b0;
                    m1_err   <= 1'b0;
                    last     <= owner;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed bench for periph_bus_ctrl: arbitration, latency, back-pressure,
// timeout, reset abandonment and write pass-through.
module tb_periph_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [3:0]  m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [3:0]  m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdata;
    logic        cmd_valid, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_busy = 1'b0;
    logic        rsp_stb = 1'b0;
    logic [31:0] rsp_word = '0;

    int checks = 0;
    int errors = 0;
    int n;

    periph_bus_ctrl #(.TIMEOUT(8), .ERR_WORD(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_busy(cmd_busy), .rsp_stb(rsp_stb), .rsp_word(rsp_word)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Simultaneous requests after reset: m0 first; m0 re-requests so the next tie goes to m1
        m0_req = 1; m0_we = 0; m0_addr = 4'h1;
        m1_req = 1; m1_we = 1; m1_addr = 4'h2; m1_wdata = 32'h0000_BEEF;
        step();
        chk("tie0_cmd_valid", cmd_valid, 1);
        chk("tie0_cmd_addr", cmd_addr, 4'h1);
        chk("tie0_cmd_write", cmd_write, 0);
        step();
        rsp_stb = 1; rsp_word = 32'h1111_0001;
        step();
        rsp_stb = 0;
        chk("tie0_m0_ack", m0_ack, 1);
        chk("tie0_m0_rdata", m0_rdata, 32'h1111_0001);
        chk("tie0_m1_ack", m1_ack, 0);
        step();
        m0_addr = 4'h5;
        step();
        chk("tie1_cmd_addr", cmd_addr, 4'h2);
        chk("tie1_cmd_write", cmd_write, 1);
        chk("tie1_cmd_data", cmd_data, 32'h0000_BEEF);
        step();
        rsp_stb = 1; rsp_word = 32'h2222_0002;
        step();
        rsp_stb = 0;
        chk("tie1_m1_ack", m1_ack, 1);
        chk("tie1_m1_rdata", m1_rdata, 32'h2222_0002);
        chk("tie1_m1_err", m1_err, 0);
        chk("tie1_m0_ack", m0_ack, 0);
        chk("tie1_m0_rdata", m0_rdata, 0);
        step();
        m1_req = 0;
        step();
        chk("pend_cmd_addr", cmd_addr, 4'h5);
        chk("pend_cmd_write", cmd_write, 0);
        step();
        rsp_stb = 1; rsp_word = 32'h3333_0003;
        step();
        rsp_stb = 0;
        chk("pend_m0_ack", m0_ack, 1);
        chk("pend_m0_rdata", m0_rdata, 32'h3333_0003);
        step();
        m0_req = 0;

        // Minimum latency read: ack in the fourth cycle
        m0_req = 1; m0_we = 0; m0_addr = 4'h3;
        step();
        chk("lat_c1_ack", m0_ack, 0);
        chk("lat_cmd_addr", cmd_addr, 4'h3);
        step();
        chk("lat_accepted", cmd_valid, 0);
        rsp_stb = 1; rsp_word = 32'h1234_5678;
        step();
        rsp_stb = 0;
        chk("lat_m0_ack", m0_ack, 1);
        chk("lat_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("lat_m0_err", m0_err, 0);
        step();
        chk("lat_ack_one_cycle", m0_ack, 0);
        chk("lat_rdata_cleared", m0_rdata, 0);
        m0_req = 0;

        // Back-pressure for 5 cycles; stray rsp_stb during ISSUE must be ignored
        m0_req = 1; m0_we = 1; m0_addr = 4'h7; m0_wdata = 32'hA5A5_0007; cmd_busy = 1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("bp_cmd_valid", cmd_valid, 1);
            chk("bp_cmd_addr", cmd_addr, 4'h7);
            chk("bp_cmd_data", cmd_data, 32'hA5A5_0007);
            rsp_stb = (i == 2); rsp_word = 32'hBAD0_0000;
            if (i == 5) cmd_busy = 0;
            step();
        end
        chk("bp_accepted", cmd_valid, 0);
        chk("bp_no_stray_ack", m0_ack, 0);
        rsp_stb = 1; rsp_word = 32'h0000_0C0D;
        step();
        rsp_stb = 0;
        chk("wr_m0_ack", m0_ack, 1);
        chk("wr_m0_rdata", m0_rdata, 32'h0000_0C0D);
        chk("wr_m0_err", m0_err, 0);
        step();
        m0_req = 0; m0_we = 0;

        // Timeout with no response
        m1_req = 1; m1_we = 0; m1_addr = 4'h9;
        n = 0;
        while (!m1_ack && n < 20) begin
            step();
            n++;
        end
        chk("to_ack", m1_ack, 1);
        chk("to_latency", n, 10);
        chk("to_rdata", m1_rdata, 32'hDEAD_BEEF);
        chk("to_err", m1_err, 1);
        chk("to_m0_ack", m0_ack, 0);
        step();
        m1_req = 0;
        chk("to_cmd_valid", cmd_valid, 0);
        chk("to_err_cleared", m1_err, 0);
        step();
        chk("to_cmd_valid_later", cmd_valid, 0);

        // Response in the same cycle as timeout: response wins
        m1_req = 1; m1_we = 0; m1_addr = 4'hB;
        for (int i = 0; i < 9; i++) step();
        chk("race_no_early_ack", m1_ack, 0);
        rsp_stb = 1; rsp_word = 32'h5555_AAAA;
        step();
        rsp_stb = 0;
        chk("race_ack", m1_ack, 1);
        chk("race_rdata", m1_rdata, 32'h5555_AAAA);
        chk("race_err", m1_err, 0);
        step();
        m1_req = 0;

        // Reset during WAIT_RSP abandons the transaction
        m0_req = 1; m0_we = 0; m0_addr = 4'h6;
        step();
        step();
        chk("rstw_pre_addr", cmd_addr, 4'h6);
        #2 rst = 0;
        #1;
        chk("rstw_cmd_addr", cmd_addr, 0);
        chk("rstw_cmd_valid", cmd_valid, 0);
        chk("rstw_m0_ack", m0_ack, 0);
        m0_req = 0;
        rsp_stb = 1; rsp_word = 32'h7777_7777;
        step();
        step();
        chk("rstw_no_ack", m0_ack, 0);
        chk("rstw_no_rdata", m0_rdata, 0);
        rsp_stb = 0;
        rst = 1;

        // m1 write after release
        m1_req = 1; m1_we = 1; m1_addr = 4'hA; m1_wdata = 32'hCAFE_0001;
        step();
        chk("m1w_cmd_valid", cmd_valid, 1);
        chk("m1w_cmd_write", cmd_write, 1);
        chk("m1w_cmd_addr", cmd_addr, 4'hA);
        chk("m1w_cmd_data", cmd_data, 32'hCAFE_0001);
        step();
        chk("m1w_accepted", cmd_valid, 0);
        rsp_stb = 1; rsp_word = 32'h0000_0A0A;
        step();
        rsp_stb = 0;
        chk("m1w_ack", m1_ack, 1);
        chk("m1w_rdata", m1_rdata, 32'h0000_0A0A);
        chk("m1w_err", m1_err, 0);
        step();
        m1_req = 0;
        chk("m1w_ack_cleared", m1_ack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_bus_ctrl.md
PERIPH_BUS_CTRL -- requirements
Module: periph_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: WAIT_RSP cycles before abort (8-bit counter).
REQ-002 SHALL have parameter ERR_WORD, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_req/m1_req  in  1  transaction request, held until ack.
REQ-006 SHALL have ports m0_we/m1_we  in  1  1=write, 0=read.
REQ-007 SHALL have ports m0_addr/m1_addr  in  4  register address.
REQ-008 SHALL have ports m0_wdata/m1_wdata  in  32  write data.
REQ-009 SHALL have ports m0_ack/m1_ack  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports m0_rdata/m1_rdata  out  32  response word, valid with ack.
REQ-011 SHALL have ports m0_err/m1_err  out  1  timeout flag, valid with ack.
REQ-012 SHALL have ports cmd_valid  out  1, cmd_write  out  1, cmd_addr  out  4, cmd_data  out  32: downstream command.
REQ-013 SHALL have ports cmd_busy  in  1, rsp_stb  in  1, rsp_word  in  32: downstream accept/response.

Function
REQ-014 SHALL implement FSM IDLE, ISSUE, WAIT_RSP, DONE.
REQ-015 IDLE: any req high -> latch winner id, we, addr, wdata; clear timer; go ISSUE next cycle.
REQ-016 Both req high in IDLE: grant the master not granted last (round-robin); single req granted regardless of pointer.
REQ-017 ISSUE: cmd_valid=1 and latched fields on cmd_*; cycle with cmd_busy=0 is acceptance -> WAIT_RSP.
REQ-018 cmd_* fields SHALL remain stable while cmd_valid=1; cmd_valid=0 in all other states.
REQ-019 WAIT_RSP: rsp_stb=1 -> capture rsp_word, err=0, go DONE.
REQ-020 Timer SHALL increment each cycle in ISSUE and WAIT_RSP; timer==TIMEOUT without rsp_stb -> data=ERR_WORD, err=1, go DONE.
REQ-021 rsp_stb and timeout in same cycle: response wins, err=0.
REQ-022 rsp_stb outside WAIT_RSP SHALL be ignored.
REQ-023 DONE: owner ack=1, rdata/err driven for exactly one cycle; non-owner ack=0, rdata=0, err=0; update round-robin pointer to owner; go IDLE.
REQ-024 Outside DONE all ack=0, rdata=0, err=0.
REQ-025 Write transactions SHALL also wait for rsp_stb; returned word passed through unchanged.
REQ-026 Requester deasserts req the cycle after ack; a req still high in IDLE is a new transaction.
REQ-027 Minimum latency req->ack = 4 cycles (IDLE, ISSUE with cmd_busy=0, WAIT_RSP with rsp_stb=1, DONE).
REQ-028 Non-granted requester's req SHALL be held pending, never dropped.

Reset
REQ-029 rst low SHALL force IDLE, timer=0, pointer=m1 (m0 wins first tie), all latched fields 0, all outputs 0, immediately and asynchronously.
REQ-030 Reset mid-transaction SHALL abandon it with no ack; first cycle after release is IDLE.

Structure
REQ-031 State encoding, ERR_WORD and TIMEOUT default SHALL reside in shared package periph_bus_pkg.
REQ-032 Round-robin grant logic SHALL be sub-module rr_arbiter2 (req[1:0], last, gnt[1:0]).

Verification
REQ-033 m0 read addr 4'h3, cmd_busy=0, rsp_stb+rsp_word=32'h1234_5678 one cycle after acceptance -> m0_ack at cycle 4, m0_rdata=32'h1234_5678, m0_err=0.
REQ-034 m0 and m1 req same cycle after reset -> m0 served first, then m1; next simultaneous pair -> m1 first.
REQ-035 cmd_busy=1 for 5 cycles -> cmd_valid held, cmd_addr/cmd_data stable, accepted on 6th cycle.
REQ-036 No rsp_stb, TIMEOUT=8 -> ack with rdata=32'hDEAD_BEEF, err=1, cmd_valid low thereafter.
REQ-037 rst low during WAIT_RSP -> outputs 0 immediately, no ack; after release new m1 write completes normally.
REQ-038 m1 write addr 4'hA data 32'hCAFE_0001 -> cmd_write=1, cmd_addr=4'hA, cmd_data=32'hCAFE_0001, m1_ack after rsp_stb.
